tas_pkt_avg: RTL and testbench

Front-end stage of the temperature averaging system (tas), running in the 50 MHz domain. Deserializes the LSB-first serial stream qualified by data_ena into bytes. Frames bytes into 5-byte packets (header plus 4 data bytes) and averages the 4 temperatures of packets whose header is A5 or C3. Emits one averaged byte per temperature packet to the write side of the clock-crossing FIFO that feeds the 2 MHz RAM writer.

---
 rtl/tas_pkg.sv | 27 ++
 rtl/tas_deser.sv | 42 ++++
 rtl/tas_pkt_avg.sv | 116 +++++++++++
 tb/tb_tas_pkt_avg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tas_pkg.sv
// Shared constants, state encoding and helpers for the temperature averaging front end.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tas_pkg;

  localparam int BYTE_W     = 8;
  localparam int DATA_BYTES = 4;
  localparam int CNT_W      = $clog2(DATA_BYTES);
  localparam int SUM_W      = BYTE_W + CNT_W;
  localparam int BIT_CNT_W  = $clog2(BYTE_W);

  localparam logic [BYTE_W-1:0] HDR_A = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR_B = 8'hC3;

  typedef enum logic [1:0] {
    HDR,
    TEMP,
    NONTEMP,
    WRITE
  } state_t;

  // True when a header byte announces a temperature packet.
  function automatic logic is_temp_hdr(input logic [BYTE_W-1:0] b);
    return (b == HDR_A) || (b == HDR_B);
  endfunction

endpackage

// File: rtl/tas_deser.sv
// LSB-first serial-to-byte deserializer qualified by data_ena.
// Latency: byte_done pulses 1 cycle after the edge sampling bit 7.
// Backpressure: none; a data_ena gap simply freezes the bit position.
module tas_deser
  import tas_pkg::*;
(
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              byte_done,
  output logic [BYTE_W-1:0] byte_dat
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-2:0]    shreg;

  // Collect qualified bits; the final bit goes straight into the output byte.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      byte_dat  <= '0;
    end else begin
      byte_done <= 1'b0;
      if (data_ena) begin
        if (bit_cnt == LAST_BIT) begin
          byte_dat  <= {serial_data, shreg};
          byte_done <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          shreg[bit_cnt] <= serial_data;
          bit_cnt        <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tas_pkt_avg.sv
// Frames bytes into header+4 packets and writes the floor average of A5/C3 packets.
// Latency: avg_wr asserts 2 cycles after the edge sampling the last bit of data byte 4.
// Backpressure: fifo_full during WRITE drops the average and sets sticky overflow.
module tas_pkt_avg
  import tas_pkg::*;
(
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  input  logic              fifo_full,
  output logic [BYTE_W-1:0] avg_data,
  output logic              avg_wr,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BYTES - 1);

  logic              byte_done;
  logic [BYTE_W-1:0] byte_dat;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [SUM_W-1:0]  sum;

  tas_deser u_deser (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .byte_done   (byte_done),
    .byte_dat    (byte_dat)
  );

  // State register.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= HDR;
    end else begin
      state <= state_nxt;
    end
  end

  // Packet framing: header picks the path, 4 data bytes later return to HDR.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (byte_done) begin
          state_nxt = is_temp_hdr(byte_dat) ? TEMP : NONTEMP;
        end
      end
      TEMP: begin
        if (byte_done && (byte_cnt == LAST_DATA)) begin
          state_nxt = WRITE;
        end
      end
      NONTEMP: begin
        if (byte_done && (byte_cnt == LAST_DATA)) begin
          state_nxt = HDR;
        end
      end
      WRITE: begin
        state_nxt = HDR;
      end
      default: begin
        state_nxt = HDR;
      end
    endcase
  end

  // Accumulate data bytes and emit the truncated average (sum >> 2) once per packet.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      sum      <= '0;
      avg_data <= '0;
      avg_wr   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      avg_wr <= 1'b0;
      case (state)
        HDR: begin
          if (byte_done) begin
            sum      <= '0;
            byte_cnt <= '0;
          end
        end
        TEMP: begin
          if (byte_done) begin
            sum      <= sum + SUM_W'(byte_dat);
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        NONTEMP: begin
          if (byte_done) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (!fifo_full) begin
            avg_data <= sum[SUM_W-1:CNT_W];
            avg_wr   <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        default: begin
          byte_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tas_pkt_avg.sv
// Directed packet vectors for tas_pkt_avg with hand-computed averages.
// Checks write count, data, latency, hold, overflow and reset behaviour.
module tb_tas_pkt_avg;

  logic       clk_50;
  logic       reset_n;
  logic       serial_data;
  logic       data_ena;
  logic       fifo_full;
  logic [7:0] avg_data;
  logic       avg_wr;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;
  int last_cyc = 0;
  logic [7:0] wr_data = 8'h00;
  logic       prev_wr = 1'b0;

  typedef struct {
    string           name;
    logic [0:4][7:0] pkt;
    int              gap;
    int              mid_gap;
    logic            full;
    int              exp_wr;
    logic [7:0]      exp_avg;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[$];

  tas_pkt_avg dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .fifo_full   (fifo_full),
    .avg_data    (avg_data),
    .avg_wr      (avg_wr),
    .overflow    (overflow)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe monitor: records each write and checks it is a single-cycle pulse.
  initial begin
    forever begin
      @(negedge clk_50);
      if (avg_wr === 1'b1) begin
        chk("avg_wr_single_cycle", {31'd0, prev_wr}, 32'd0);
        wr_cnt++;
        wr_data = avg_data;
        wr_cyc  = cyc;
      end
      prev_wr = avg_wr;
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk_50);
    data_ena    = 1'b1;
    serial_data = b;
    @(posedge clk_50);
    #1 last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_50);
      data_ena    = 1'b0;
      serial_data = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int mid);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (i == 3 && mid > 0) idle(mid);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w0;
    fifo_full = v.full;
    w0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      send_byte(v.pkt[k], v.mid_gap);
      if (k < 4) idle(v.gap);
    end
    idle(12);
    chk({v.name, "_writes"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
    if (v.exp_wr > 0 && wr_cnt > w0) begin
      chk({v.name, "_wr_data"}, {24'd0, wr_data}, {24'd0, v.exp_avg});
      chk({v.name, "_latency"}, 32'(wr_cyc - last_cyc), 32'd2);
    end
    chk({v.name, "_avg_hold"}, {24'd0, avg_data}, {24'd0, v.exp_avg});
    chk({v.name, "_overflow"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
  endtask

  initial begin
    vec_t rv;

    vecs.push_back('{"light",    {8'hA5, 8'h3A, 8'h55, 8'h43, 8'h3C}, 4,   0,  1'b0, 1, 8'h43,   1'b0});
    vecs.push_back('{"burst_g1", {8'hA5, 8'd10, 8'd20, 8'd30, 8'd40}, 1,   0,  1'b0, 1, 8'd25,   1'b0});
    vecs.push_back('{"burst_g0", {8'hA5, 8'd10, 8'd20, 8'd30, 8'd40}, 0,   0,  1'b0, 1, 8'd25,   1'b0});
    vecs.push_back('{"split_a5", {8'hA5, 8'd2,  8'd4,  8'd6,  8'd8},  200, 0,  1'b0, 1, 8'd5,    1'b0});
    vecs.push_back('{"split_c3", {8'hC3, 8'd10, 8'd12, 8'd14, 8'd16}, 200, 60, 1'b0, 1, 8'd13,   1'b0});
    vecs.push_back('{"t127",     {8'hA5, 8'd127, 8'd127, 8'd127, 8'd127}, 2, 0, 1'b0, 1, 8'd127, 1'b0});
    vecs.push_back('{"trunc",    {8'hC3, 8'd26, 8'd28, 8'd30, 8'd31}, 3,   0,  1'b0, 1, 8'd28,   1'b0});
    vecs.push_back('{"max",      {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0,   0,  1'b0, 1, 8'd255,  1'b0});
    vecs.push_back('{"nontemp1", {8'h83, 8'hA5, 8'hC3, 8'hA5, 8'hC3}, 2,   0,  1'b0, 0, 8'd255,  1'b0});
    vecs.push_back('{"nontemp2", {8'hC2, 8'hA5, 8'hC3, 8'hA5, 8'hC3}, 0,   0,  1'b0, 0, 8'd255,  1'b0});
    vecs.push_back('{"realign",  {8'hA5, 8'd34, 8'd36, 8'd38, 8'd40}, 1,   0,  1'b0, 1, 8'd37,   1'b0});
    vecs.push_back('{"full",     {8'hA5, 8'd42, 8'd44, 8'd46, 8'd48}, 1,   0,  1'b1, 0, 8'd37,   1'b1});
    vecs.push_back('{"after_ovf",{8'hA5, 8'd42, 8'd44, 8'd46, 8'd48}, 1,   0,  1'b0, 1, 8'd45,   1'b1});
    vecs.push_back('{"hdr_data", {8'hA5, 8'hA5, 8'hC3, 8'hA5, 8'hC3}, 0,   0,  1'b0, 1, 8'd180,  1'b1});

    reset_n     = 1'b0;
    data_ena    = 1'b0;
    serial_data = 1'b0;
    fifo_full   = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("reset_avg_data", {24'd0, avg_data}, 32'd0);
    chk("reset_avg_wr",   {31'd0, avg_wr},   32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    idle(4);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Reset pulsed in the middle of a byte: partial bits and overflow are discarded.
    fifo_full = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    #3;
    reset_n  = 1'b0;
    data_ena = 1'b0;
    #2;
    chk("midreset_avg_data", {24'd0, avg_data}, 32'd0);
    chk("midreset_avg_wr",   {31'd0, avg_wr},   32'd0);
    chk("midreset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk_50);
    reset_n = 1'b1;
    idle(3);
    rv = '{"post_reset", {8'hA5, 8'd1, 8'd2, 8'd3, 8'd4}, 1, 0, 1'b0, 1, 8'd2, 1'b0};
    run_vec(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
